// File: rtl/ex_muldiv_seq_if.sv
// Purpose: EX-stage handshake and operand/result bundle for the iterative RV32M sequencer.
// Ports: start_i/op_i/rs1_i/rs2_i/flush_i from the pipeline; stall_o/busy_o/done_o/result_o back.
// Modports: master = pipeline (ID/EX + hazard unit), slave = ex_muldiv_seq.
interface ex_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Purpose: iterative RV32M multiply/divide beside the EX ALU; shift-add multiplier and
//   restoring divider share one 64-bit working register, one op in flight.
// Ports: clk, rst (sync, active-high), bus (ex_muldiv_seq_if.slave: start/op/rs1/rs2/flush
//   in; stall/busy/done/result out).
// Latency: start in cycle 0, BUSY cycles 1..32, done_o for one cycle in cycle 33.
// Option: define MULDIV_EARLY_OUT_EN to send zero-operand, divide-by-zero and signed
//   overflow cases straight from IDLE to DONE (done_o in cycle 1).
module ex_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic         clk,
  input logic         rst,
  ex_muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  state_t            state, state_nxt;
  logic [4:0]        cnt;
  logic [2*XLEN-1:0] work;      // mul: {acc_hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd;      // multiplicand magnitude or divisor
  logic [XLEN-1:0]   result;
  logic [2:0]        op_q;
  logic              a_neg_q, b_neg_q, nz1_q, nz2_q;

  // ---------------- operand decode at acceptance ----------------
  logic            accept;
  logic            in_div, in_a_sgn, in_b_sgn, in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_a_mag, in_b_mag;
  logic            special;

  assign accept = (state == S_IDLE) && bus.start_i && !bus.flush_i;
  assign in_div = bus.op_i[2];

  always_comb begin
    in_a_sgn = 1'b0;
    in_b_sgn = 1'b0;
    case (bus.op_i)
      3'b000, 3'b001: begin in_a_sgn = 1'b1; in_b_sgn = 1'b1; end  // MUL, MULH
      3'b010:         begin in_a_sgn = 1'b1; in_b_sgn = 1'b0; end  // MULHSU
      3'b100, 3'b110: begin in_a_sgn = 1'b1; in_b_sgn = 1'b1; end  // DIV, REM
      default:        begin in_a_sgn = 1'b0; in_b_sgn = 1'b0; end  // MULHU, DIVU, REMU
    endcase
  end

  assign in_a_neg = in_a_sgn && bus.rs1_i[XLEN-1];
  assign in_b_neg = in_b_sgn && bus.rs2_i[XLEN-1];
  assign in_a_mag = in_a_neg ? ('0 - bus.rs1_i) : bus.rs1_i;
  assign in_b_mag = in_b_neg ? ('0 - bus.rs2_i) : bus.rs2_i;

`ifdef MULDIV_EARLY_OUT_EN
  logic            in_zero, in_ovf;
  logic [XLEN-1:0] special_res;

  assign in_zero = (bus.rs1_i == '0) || (bus.rs2_i == '0);
  assign in_ovf  = in_div && !bus.op_i[0] &&
                   (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
  assign special = in_zero || in_ovf;

  // Architectural results for the short-circuited cases.
  always_comb begin
    special_res = '0;
    if (in_div) begin
      if (bus.rs2_i == '0)
        special_res = bus.op_i[1] ? bus.rs1_i : '1;
      else if (in_ovf)
        special_res = bus.op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      else
        special_res = '0;  // dividend zero: quotient and remainder both zero
    end
  end
`else
  assign special = 1'b0;
`endif

  // ---------------- one iteration of the shared datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] work_mul, work_div, work_step;

  // Shift-add: add multiplicand into the high half when the current multiplier
  // LSB is set, then shift the whole 65-bit {carry, hi, lo} right by one.
  assign mul_sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
  assign work_mul = {mul_sum, work[XLEN-1:1]};

  // Restoring: trial-subtract divisor from the left-shifted remainder (33 bits);
  // a borrow keeps the shifted remainder and shifts in a 0 quotient bit.
  assign div_diff = {1'b0, work[2*XLEN-1:XLEN-1]} - {2'b00, opnd};
  assign work_div = {div_diff[XLEN+1] ? work[2*XLEN-2:XLEN-1] : div_diff[XLEN-1:0],
                     work[XLEN-2:0], ~div_diff[XLEN+1]};

  assign work_step = op_q[2] ? work_div : work_mul;

  // ---------------- sign fix-up of the final iteration ----------------
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   mul_res, quo, rem, quo_fin, rem_fin, div_res, fin_res;

  assign prod_fin = (a_neg_q ^ b_neg_q) ? ('0 - work_step) : work_step;
  assign mul_res  = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  assign quo      = work_step[XLEN-1:0];
  assign rem      = work_step[2*XLEN-1:XLEN];
  // With a zero divisor the raw quotient is already all ones; never negate it.
  assign quo_fin  = ((a_neg_q ^ b_neg_q) && nz2_q) ? ('0 - quo) : quo;
  assign rem_fin  = (a_neg_q && nz1_q) ? ('0 - rem) : rem;
  assign div_res  = op_q[1] ? rem_fin : quo_fin;
  assign fin_res  = op_q[2] ? div_res : mul_res;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  logic stall, busy, done;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = special ? S_DONE : S_BUSY;
        stall = accept;
      end
      S_BUSY: begin
        if (cnt == CNT_LAST) state_nxt = S_DONE;
        stall = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        busy      = 1'b1;
        done      = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) state_nxt = S_IDLE;
    if (rst)         stall     = 1'b0;
  end

  assign bus.stall_o  = stall;
  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = result;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      work    <= '0;
      opnd    <= '0;
      result  <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      nz1_q   <= 1'b0;
      nz2_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= bus.op_i;
            a_neg_q <= in_a_neg;
            b_neg_q <= in_b_neg;
            nz1_q   <= |bus.rs1_i;
            nz2_q   <= |bus.rs2_i;
            cnt     <= '0;
            work    <= in_div ? {{XLEN{1'b0}}, in_a_mag} : {{XLEN{1'b0}}, in_b_mag};
            opnd    <= in_div ? in_b_mag : in_a_mag;
`ifdef MULDIV_EARLY_OUT_EN
            if (special) result <= special_res;
`endif
          end
        end
        S_BUSY: begin
          if (!bus.flush_i) begin
            work <= work_step;
            if (cnt == CNT_LAST) result <= fin_res;  // counter parks at ITER-1
            else                 cnt    <= cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
